// File: rtl/mac_fifo_pkg.sv
// Shared MAC FIFO definitions: FSM state codes and default payload size.
// Used by both the TX writer and the RX reader.
package mac_fifo_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] WORK = 3'd2;
  localparam logic [2:0] LAST = 3'd3;

  localparam int BYTES_DEF = 12;

endpackage

// File: rtl/fifo_write.sv
// MAC TX producer: snapshots a payload on fs, writes it byte 0 first
// into the TX FIFO with full back-pressure, then holds fd until fs drops.
module fifo_write
  import mac_fifo_pkg::*;
#(
  parameter int BYTES = BYTES_DEF,
  parameter int CW    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        FIFO_NUM,
  input  logic [0:BYTES*8-1]   din,
  input  logic                 fifo_full,
  output logic                 fifo_txen,
  output logic [7:0]           fifo_txd,
  input  logic                 fs,
  output logic                 fd,
  output logic                 err
);

  logic [2:0]         state;
  logic [2:0]         state_nx;
  logic [0:BYTES*8-1] shreg;
  logic [3:0]         count;
  logic [3:0]         num;
  logic [3:0]         clamp;
  logic               over;

  // Full-width compare so large counts never alias onto small ones.
  assign over  = FIFO_NUM > CW'(BYTES);
  assign clamp = over ? 4'(BYTES) : 4'(FIFO_NUM);

  assign fifo_txen = (state == WORK) && !fifo_full;
  assign fifo_txd  = shreg[0:7];
  assign fd        = (state == LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (fs) state_nx = LOAD;
      LOAD: state_nx = (clamp != 4'd0) ? WORK : LAST;
      WORK: begin
        if (fifo_txen && count == num - 4'd1)
          state_nx = LAST;
      end
      LAST: if (!fs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      count <= '0;
      num   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: begin
          shreg <= din;
          count <= '0;
          num   <= clamp;
          err   <= over;
        end
        WORK: begin
          if (fifo_txen) begin
            shreg <= {shreg[8:BYTES*8-1], 8'h00};
            count <= count + 4'd1;
          end
        end
        LAST: if (!fs) err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write.sv
// Directed bench for fifo_write: frame table plus stall,
// reset-abort and input-change sequences.
module tb_fifo_write;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] FIFO_NUM;
  logic [0:95] din;
  logic        fifo_full;
  logic        fifo_txen;
  logic [7:0]  fifo_txd;
  logic        fs;
  logic        fd;
  logic        err;

  int checks = 0;
  int errors = 0;

  fifo_write dut (
    .clk       (clk),
    .rst       (rst),
    .FIFO_NUM  (FIFO_NUM),
    .din       (din),
    .fifo_full (fifo_full),
    .fifo_txen (fifo_txen),
    .fifo_txd  (fifo_txd),
    .fs        (fs),
    .fd        (fd),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] n;
    logic [0:95] d;
    int          exp_w;
    logic        exp_e;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int w;
    int lat;
    bit got;
    logic [7:0] eb;
    w = 0;
    lat = 0;
    got = 0;
    @(negedge clk);
    FIFO_NUM = v.n;
    din = v.d;
    fs = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      #1;
      lat++;
      if (fifo_txen) begin
        eb = (w < 12) ? v.d[w*8 +: 8] : 8'hxx;
        chk("txd", 32'(fifo_txd), 32'(eb));
        w++;
      end
      if (fd) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL fd_timeout got 0 want 1");
    end
    chk("writes", 32'(w), 32'(v.exp_w));
    chk("err", 32'(err), 32'(v.exp_e));
    chk("latency", 32'(lat), 32'(v.exp_lat));
    fs = 1'b0;
    @(negedge clk);
    #1;
    chk("fd_drop", 32'(fd), 32'd0);
    chk("err_clr", 32'(err), 32'd0);
  endtask

  vec_t tbl[7];
  logic [0:95] seq;

  initial begin
    seq = 96'h000102030405060708090A0B;
    tbl[0] = '{12'd12,  seq, 12, 1'b0, 14};
    tbl[1] = '{12'd0,   seq, 0,  1'b0, 2};
    tbl[2] = '{12'd20,  96'hF0E1D2C3B4A5968778695A4B, 12, 1'b1, 14};
    tbl[3] = '{12'd1,   96'hA5000000000000000000005A, 1,  1'b0, 3};
    tbl[4] = '{12'd13,  seq, 12, 1'b1, 14};
    tbl[5] = '{12'hFFC, seq, 12, 1'b1, 14};
    tbl[6] = '{12'h010, seq, 12, 1'b1, 14};

    rst = 1'b1;
    fs = 1'b0;
    fifo_full = 1'b0;
    FIFO_NUM = '0;
    din = '0;
    #1;
    chk("rst_txen", 32'(fifo_txen), 32'd0);
    chk("rst_txd", 32'(fifo_txd), 32'd0);
    chk("rst_fd", 32'(fd), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // Stall: full asserted for 5 cycles after the second write.
    @(negedge clk);
    FIFO_NUM = 12'd3;
    din = 96'hC0C1C2C3C4C50000_00000000;
    fs = 1'b1;
    @(negedge clk); #1;
    chk("st_load_txen", 32'(fifo_txen), 32'd0);
    @(negedge clk); #1;
    chk("st_b0", {fifo_txen, fifo_txd}, {1'b1, 8'hC0});
    @(negedge clk); #1;
    chk("st_b1", {fifo_txen, fifo_txd}, {1'b1, 8'hC1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      #1;
      chk("st_hold", {fifo_txen, fifo_txd, fd}, {1'b0, 8'hC2, 1'b0});
    end
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    chk("st_b2", {fifo_txen, fifo_txd}, {1'b1, 8'hC2});
    @(negedge clk); #1;
    chk("st_done", {fifo_txen, fd}, {1'b0, 1'b1});
    fs = 1'b0;
    @(negedge clk); #1;
    chk("st_idle", {fifo_txen, fd}, {1'b0, 1'b0});

    // Reset while byte 5 of an oversized frame is presented.
    @(negedge clk);
    FIFO_NUM = 12'd20;
    din = seq;
    fs = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("ra_err", 32'(err), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("ra_b5", {fifo_txen, fifo_txd}, {1'b1, 8'h05});
    rst = 1'b1;
    #1;
    chk("ra_abort", {fifo_txen, fifo_txd, fd, err}, 11'd0);
    fs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(tbl[0]);

    // Inputs changed and fs dropped mid-frame: frame completes as loaded.
    @(negedge clk);
    FIFO_NUM = 12'd4;
    din = 96'h1122334455667788_99AABBCC;
    fs = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("ch_b0", {fifo_txen, fifo_txd}, {1'b1, 8'h11});
    @(negedge clk); #1;
    chk("ch_b1", {fifo_txen, fifo_txd}, {1'b1, 8'h22});
    din = '0;
    FIFO_NUM = 12'd12;
    fs = 1'b0;
    @(negedge clk); #1;
    chk("ch_b2", {fifo_txen, fifo_txd}, {1'b1, 8'h33});
    @(negedge clk); #1;
    chk("ch_b3", {fifo_txen, fifo_txd}, {1'b1, 8'h44});
    @(negedge clk); #1;
    chk("ch_last", {fifo_txen, fd, err}, {1'b0, 1'b1, 1'b0});
    @(negedge clk); #1;
    chk("ch_idle", {fifo_txen, fd}, {1'b0, 1'b0});
    @(negedge clk); #1;
    chk("ch_quiet", {fifo_txen, fd}, {1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
